master_port: RTL
================

Name: master_port

Overview:
- Initiator-side serial bus port; the counterpart of the slave port on the same one-bit serial bus.
- Accepts one parallel read/write request from a local master device and arbitrates for the bus.
- Shifts address (and write data) out LSB-first, then shifts read data in LSB-first and returns it in parallel.
- Supports split reads (slave releases the bus and returns data later) and a read-response timeout.

Parameters:
ADDR_WIDTH, 12, slave-local address bits shifted per transaction
DATA_WIDTH, 8, data bits per transfer
TIMEOUT, 64, cycles to wait for first read bit (non-split) before abort; must be >= 2

Ports:
clk  in  1  clock, all logic on rising edge
rstn  in  1  synchronous active-low reset
dstart  in  1  device request strobe, sampled only when dready=1
dmode  in  1  0 read, 1 write
daddr  in  ADDR_WIDTH  target address
dwdata  in  DATA_WIDTH  write data
drdata  out  DATA_WIDTH  read data, valid when dvalid=1
dvalid  out  1  one-cycle completion pulse (read or write)
derr  out  1  qualifies dvalid: 1 = read timed out
dready  out  1  port idle, can accept dstart
mbreq  out  1  bus request to arbiter
mbgrant  in  1  bus grant from arbiter
mwdata  out  1  serial address/write-data bit
mmode  out  1  transaction mode to slave
mvalid  out  1  mwdata valid
srdata  in  1  serial read data bit from slave
svalid  in  1  srdata valid
sready  in  1  addressed slave idle
ssplit  in  1  slave has split the transaction

Behaviour:
- Reset (rstn=0 at a clock edge): state IDLE. All outputs 0 except dready=1. Shift counters, timeout counter and latched request cleared. An in-flight transaction is dropped with no dvalid; reset overrides every other event.
- Registers: all outputs are registered. mwdata/mmode/mvalid change only on clock edges.
- State encoding: IDLE, REQ, ADDR, WDATA, RWAIT, RDATA, SPLIT, DONE. dready = (state==IDLE).
- IDLE: on dstart=1, latch daddr/dwdata/dmode and go to REQ.
- REQ: mbreq=1. Go to ADDR when mbgrant=1 and sready=1 in the same cycle.
- ADDR: mbreq=1, mmode=latched mode.
  - Each cycle with mbgrant=1: mvalid=1, mwdata=addr[cnt], cnt++.
  - If mbgrant=0: mvalid=0 and cnt holds (pause, no bit lost).
  - After bit ADDR_WIDTH-1 is sent, cnt resets to 0 and the port goes to WDATA (write) or RWAIT (read).
- WDATA: same pacing and pause rule, sending wdata[0..DATA_WIDTH-1]. After the last bit go to DONE.
- RWAIT: mbreq=1, mvalid=0; tcnt increments each cycle.
  - svalid=1: capture srdata into bit 0, cnt=1, go to RDATA.
  - ssplit=1 (and svalid=0): go to SPLIT, clear tcnt.
  - tcnt reaches TIMEOUT-1 with neither event: go to DONE with error flag set.
  - svalid and ssplit in the same cycle: svalid wins.
- SPLIT: mbreq=0, no timeout. On svalid=1, capture bit 0 and go to RDATA.
- RDATA: each svalid=1 cycle captures srdata into rdata[cnt], cnt++. svalid=0 cycles hold. After bit DATA_WIDTH-1, go to DONE.
- DONE (1 cycle):
  - dvalid=1; derr=error flag.
  - drdata = assembled read data, or 0 on error/write; holds value until the next DONE.
  - mbreq=0, then return to IDLE. dstart during DONE is ignored.
- Latency (grant and sready already high, no pause):
  - dstart at cycle 0 -> REQ cycle 1 -> ADDR cycles 2..ADDR_WIDTH+1.
  - Write: WDATA for the next DATA_WIDTH cycles; dvalid in the cycle after the last data bit (cycle 22 with defaults).
- mvalid is never asserted outside ADDR/WDATA. mbreq is never asserted in IDLE/SPLIT/DONE.

Test Plan:
- Write: dstart, dmode=1, daddr=0xA5C, dwdata=0x3B; grant held -> mvalid high 20 cycles; mwdata sequence = 0,0,1,1,1,0,1,0,0,1,0,1 then 1,1,0,1,1,1,0,0; mmode=1; dvalid=1, derr=0 at cycle 22; mbreq low after.
- Read: daddr=0x00F, dmode=0; slave drives svalid 8 cycles with bits of 0xC6 LSB-first after 3-cycle gap -> drdata=0xC6, dvalid one cycle, derr=0.
- Split read: after address, ssplit=1 -> mbreq drops next cycle; 20 idle cycles (no timeout); then svalid burst 0x81 -> drdata=0x81, derr=0.
- Timeout: read, slave never responds, TIMEOUT=64 -> dvalid=1, derr=1, drdata=0 exactly 64 cycles after entering RWAIT.
- Grant pause: drop mbgrant for 3 cycles after address bit 4 -> mvalid=0 those cycles; bit 5 sent on regrant; full address still correct; dstart while busy ignored.
- Reset mid-WDATA: rstn=0 one edge -> all outputs 0, dready=1, no dvalid; next write completes normally.

Source files
------------

// File: rtl/master_port.sv
// Initiator port for the one-bit serial bus: parallel request in, serial address/data out, serial read data in.
// Latency: REQ one cycle after dstart, then one bit per granted cycle; dvalid in the cycle after the last bit.
// Backpressure: dready low while busy; mbgrant=0 pauses shifting; svalid=0 stalls read capture.
module master_port #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  dstart,
  input  logic                  dmode,
  input  logic [ADDR_WIDTH-1:0] daddr,
  input  logic [DATA_WIDTH-1:0] dwdata,
  output logic [DATA_WIDTH-1:0] drdata,
  output logic                  dvalid,
  output logic                  derr,
  output logic                  dready,
  output logic                  mbreq,
  input  logic                  mbgrant,
  output logic                  mwdata,
  output logic                  mmode,
  output logic                  mvalid,
  input  logic                  srdata,
  input  logic                  svalid,
  input  logic                  sready,
  input  logic                  ssplit
);

  localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW   = $clog2(MAXW + 1);
  localparam int TW   = $clog2(TIMEOUT);
  localparam logic [CW-1:0] A_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_ADDR, S_WDATA, S_RWAIT, S_RDATA, S_SPLIT, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;    // shifts right as bits go out
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;  // shifts right as bits go out
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;  // fills from the MSB so bit 0 ends up first
  logic                  mode_q, mode_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] drdata_q, drdata_d;
  logic                  dvalid_q, dvalid_d, derr_q, derr_d, dready_q, dready_d;
  logic                  mbreq_q, mbreq_d, mwdata_q, mwdata_d, mmode_q, mmode_d, mvalid_q, mvalid_d;

  // Next-state, datapath and registered-output decode; outputs look ahead at state_d.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tcnt_d   = tcnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    mode_d   = mode_q;
    err_d    = err_q;
    drdata_d = drdata_q;
    dvalid_d = 1'b0;
    derr_d   = 1'b0;
    mvalid_d = 1'b0;
    mwdata_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        tcnt_d = '0;
        err_d  = 1'b0;
        if (dstart) begin
          addr_d  = daddr;
          wdata_d = dwdata;
          mode_d  = dmode;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (mbgrant && sready) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (mbgrant) begin
          mvalid_d = 1'b1;
          mwdata_d = addr_q[0];
          addr_d   = addr_q >> 1;
          if (cnt_q == A_LAST) begin
            cnt_d   = '0;
            tcnt_d  = '0;
            state_d = mode_q ? S_WDATA : S_RWAIT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_WDATA: begin
        if (mbgrant) begin
          mvalid_d = 1'b1;
          mwdata_d = wdata_q[0];
          wdata_d  = wdata_q >> 1;
          if (cnt_q == D_LAST) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_RWAIT: begin
        tcnt_d = tcnt_q + 1'b1;
        if (svalid) begin
          rdata_d = {srdata, rdata_q[DATA_WIDTH-1:1]};
          cnt_d   = CW'(1);
          state_d = (DATA_WIDTH == 1) ? S_DONE : S_RDATA;
        end else if (ssplit) begin
          tcnt_d  = '0;
          state_d = S_SPLIT;
        end else if (tcnt_q == T_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_SPLIT: begin
        if (svalid) begin
          rdata_d = {srdata, rdata_q[DATA_WIDTH-1:1]};
          cnt_d   = CW'(1);
          state_d = (DATA_WIDTH == 1) ? S_DONE : S_RDATA;
        end
      end
      S_RDATA: begin
        if (svalid) begin
          rdata_d = {srdata, rdata_q[DATA_WIDTH-1:1]};
          if (cnt_q == D_LAST) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Completion is flagged on entry so dvalid is visible during the DONE cycle.
    if (state_d == S_DONE && state_q != S_DONE) begin
      dvalid_d = 1'b1;
      derr_d   = err_d;
      drdata_d = (err_d || mode_q) ? '0 : rdata_d;
    end

    mbreq_d  = (state_d == S_REQ) || (state_d == S_ADDR) || (state_d == S_WDATA) || (state_d == S_RWAIT);
    // Mode stays up while the final shifted bit is still on the wire.
    mmode_d  = ((state_d == S_ADDR) || (state_d == S_WDATA) || mvalid_d) ? mode_d : 1'b0;
    dready_d = (state_d == S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      tcnt_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      mode_q   <= 1'b0;
      err_q    <= 1'b0;
      drdata_q <= '0;
      dvalid_q <= 1'b0;
      derr_q   <= 1'b0;
      dready_q <= 1'b1;
      mbreq_q  <= 1'b0;
      mwdata_q <= 1'b0;
      mmode_q  <= 1'b0;
      mvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tcnt_q   <= tcnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      mode_q   <= mode_d;
      err_q    <= err_d;
      drdata_q <= drdata_d;
      dvalid_q <= dvalid_d;
      derr_q   <= derr_d;
      dready_q <= dready_d;
      mbreq_q  <= mbreq_d;
      mwdata_q <= mwdata_d;
      mmode_q  <= mmode_d;
      mvalid_q <= mvalid_d;
    end
  end

  assign drdata = drdata_q;
  assign dvalid = dvalid_q;
  assign derr   = derr_q;
  assign dready = dready_q;
  assign mbreq  = mbreq_q;
  assign mwdata = mwdata_q;
  assign mmode  = mmode_q;
  assign mvalid = mvalid_q;

endmodule
